sort_checker: RTL and testbench

Post-sort verification stage sitting directly downstream of the bubble-sort engine on the shared 256×8 on-chip memory port. Once the sorter has finished and handed the memory back, the top-level controller pulses `enable`. The checker then streams `mem[0..length-1]` read-only, confirms the contents are non-decreasing, and reports the result. The reported result is pass/fail, the first out-of-order index, the minimum and maximum values, and an optional checksum, held for display on the HEX/LED outputs.

---
 rtl/sort_checker_if.sv | 27 ++
 rtl/sort_checker.sv | 136 +++++++++++++
 tb/tb_sort_checker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sort_checker_if.sv
// Controller/memory-side bundle for sort_checker: start handshake, read port and result outputs.
interface sort_checker_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic                       enable;
  logic                       ready;
  logic [9:0]                 length;
  logic [ADDR_W-1:0]          address;
  logic [DATA_W-1:0]          rdata;
  logic                       done;
  logic                       pass;
  logic [ADDR_W:0]            fail_idx;
  logic [DATA_W-1:0]          min_val;
  logic [DATA_W-1:0]          max_val;
  logic [ADDR_W+DATA_W-1:0]   checksum;

  modport master (
    output enable, length, rdata,
    input  ready, address, done, pass, fail_idx, min_val, max_val, checksum
  );

  modport slave (
    input  enable, length, rdata,
    output ready, address, done, pass, fail_idx, min_val, max_val, checksum
  );
endinterface

// File: rtl/sort_checker.sv
// Read-only post-sort check: streams mem[0..len-1], reports order, first violation, min/max.
// Optional checksum accumulator built only when SORT_CHECK_SUM_EN is defined.
module sort_checker #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  sort_checker_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int unsigned      DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [1:0]        state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_clamp;
  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W:0]   k;
  logic [ADDR_W-1:0] address_r;
  logic              ready_r;
  logic              done_r;
  logic              pass_r;
  logic              violation;
  logic [ADDR_W:0]   fail_idx_r;
  logic [DATA_W-1:0] min_r;
  logic [DATA_W-1:0] max_r;
  logic [DATA_W-1:0] prev;
  logic              accept;
  logic              addr_more;
  logic              last_elem;

  always_comb begin
    len_clamp = '0;
    if (32'(bus.length) > DEPTH) len_clamp = (ADDR_W+1)'(DEPTH);
    else                         len_clamp = (ADDR_W+1)'(bus.length);
  end

  // ready_r is high exactly while idle, so it doubles as the acceptance qualifier
  assign accept    = ready_r && bus.enable;
  assign len_m1    = len - CNT_ONE;
  assign addr_more = {1'b0, address_r} < len_m1;
  assign last_elem = (k == len_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= '0;
      k          <= '0;
      address_r  <= '0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      violation  <= 1'b0;
      fail_idx_r <= '0;
      min_r      <= '0;
      max_r      <= '0;
      prev       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            len        <= len_clamp;
            k          <= '0;
            address_r  <= '0;
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            violation  <= 1'b0;
            fail_idx_r <= '0;
            min_r      <= '0;
            max_r      <= '0;
            state      <= (len_clamp == '0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: begin
          if (addr_more) address_r <= address_r + ADDR_ONE;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (addr_more) address_r <= address_r + ADDR_ONE;
          if (k == '0) begin
            min_r <= bus.rdata;
            max_r <= bus.rdata;
          end else begin
            if ((bus.rdata < prev) && !violation) begin
              fail_idx_r <= k;
              violation  <= 1'b1;
            end
            if (bus.rdata < min_r) min_r <= bus.rdata;
            if (bus.rdata > max_r) max_r <= bus.rdata;
          end
          prev <= bus.rdata;
          k    <= k + CNT_ONE;
          if (last_elem) state <= S_FINISH;
        end
        S_FINISH: begin
          pass_r  <= !violation;
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SORT_CHECK_SUM_EN
  logic [ADDR_W+DATA_W-1:0] sum_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sum_r <= '0;
    else if (accept)          sum_r <= '0;
    else if (state == S_SCAN) sum_r <= sum_r + (ADDR_W+DATA_W)'(bus.rdata);
  end

  assign bus.checksum = sum_r;
`else
  assign bus.checksum = '0;
`endif

  assign bus.ready    = ready_r;
  assign bus.address  = address_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.fail_idx = fail_idx_r;
  assign bus.min_val  = min_r;
  assign bus.max_val  = max_r;

endmodule

// File: tb/tb_sort_checker.sv
// Directed self-checking bench for sort_checker with a registered-read 256x8 memory model.
module tb_sort_checker;

`ifdef SORT_CHECK_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic CLOCK_50;
  logic rst;
  logic [7:0] mem [0:255];

  int errors = 0;
  int checks = 0;
  int busy;
  int amax;
  bit wrap;

  sort_checker_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  sort_checker #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk (CLOCK_50),
    .rst (rst),
    .bus (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) bus.rdata <= mem[bus.address];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_sum(input logic [31:0] s);
    return SUM_ON ? s : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [9:0] len, input bit hold);
    @(negedge CLOCK_50);
    bus.enable = 1'b1;
    bus.length = len;
    @(negedge CLOCK_50);
    if (!hold) begin
      bus.enable = 1'b0;
      bus.length = 10'd2;
    end
  endtask

  task automatic wait_idle(output int nbusy, output int namax, output bit nwrap);
    int last_a;
    nbusy = 0; namax = 0; nwrap = 1'b0; last_a = 0;
    while (bus.ready !== 1'b1 && nbusy < 1000) begin
      nbusy++;
      if (int'(bus.address) < last_a) nwrap = 1'b1;
      last_a = int'(bus.address);
      if (last_a > namax) namax = last_a;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic load5();
    mem[0] = 8'd3; mem[1] = 8'd5; mem[2] = 8'd4; mem[3] = 8'd7; mem[4] = 8'd1;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.length = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b0;
    @(negedge CLOCK_50);

    chk("rst_ready",    32'(bus.ready),    32'd1);
    chk("rst_address",  32'(bus.address),  32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_pass",     32'(bus.pass),     32'd0);
    chk("rst_fail_idx", 32'(bus.fail_idx), 32'd0);
    chk("rst_min",      32'(bus.min_val),  32'd0);
    chk("rst_max",      32'(bus.max_val),  32'd0);
    chk("rst_checksum", 32'(bus.checksum), 32'd0);

    // ramp 0..9
    kick(10'd10, 1'b0);
    chk("ramp_ready_low", 32'(bus.ready), 32'd0);
    wait_idle(busy, amax, wrap);
    chk("ramp_busy",     32'(busy),         32'd12);
    chk("ramp_done",     32'(bus.done),     32'd1);
    chk("ramp_pass",     32'(bus.pass),     32'd1);
    chk("ramp_fail_idx", 32'(bus.fail_idx), 32'd0);
    chk("ramp_min",      32'(bus.min_val),  32'd0);
    chk("ramp_max",      32'(bus.max_val),  32'd9);
    chk("ramp_checksum", 32'(bus.checksum), exp_sum(32'd45));
    chk("ramp_amax",     32'(amax),         32'd9);

    // 3,5,4,7,1: first violation at index 2
    load5();
    kick(10'd5, 1'b0);
    chk("unsorted_done_clr", 32'(bus.done), 32'd0);
    wait_idle(busy, amax, wrap);
    chk("unsorted_busy",     32'(busy),         32'd7);
    chk("unsorted_done",     32'(bus.done),     32'd1);
    chk("unsorted_pass",     32'(bus.pass),     32'd0);
    chk("unsorted_fail_idx", 32'(bus.fail_idx), 32'd2);
    chk("unsorted_min",      32'(bus.min_val),  32'd1);
    chk("unsorted_max",      32'(bus.max_val),  32'd7);
    chk("unsorted_checksum", 32'(bus.checksum), exp_sum(32'd20));
    repeat (3) @(negedge CLOCK_50);
    chk("unsorted_hold_fail_idx", 32'(bus.fail_idx), 32'd2);

    // zero length
    kick(10'd0, 1'b0);
    chk("zero_pass_clr", 32'(bus.pass), 32'd0);
    wait_idle(busy, amax, wrap);
    chk("zero_busy",     32'(busy),         32'd1);
    chk("zero_done",     32'(bus.done),     32'd1);
    chk("zero_pass",     32'(bus.pass),     32'd1);
    chk("zero_addr",     32'(bus.address),  32'd0);
    chk("zero_amax",     32'(amax),         32'd0);
    chk("zero_min",      32'(bus.min_val),  32'd0);
    chk("zero_checksum", 32'(bus.checksum), 32'd0);

    // clamp 1023 -> 256, all 0xFF
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    kick(10'd1023, 1'b0);
    wait_idle(busy, amax, wrap);
    chk("clamp_busy",     32'(busy),         32'd258);
    chk("clamp_pass",     32'(bus.pass),     32'd1);
    chk("clamp_amax",     32'(amax),         32'd255);
    chk("clamp_wrap",     32'(wrap),         32'd0);
    chk("clamp_min",      32'(bus.min_val),  32'd255);
    chk("clamp_max",      32'(bus.max_val),  32'd255);
    chk("clamp_checksum", 32'(bus.checksum), exp_sum(32'd65280));

    // enable pulse mid-scan is ignored
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    kick(10'd10, 1'b0);
    repeat (4) @(negedge CLOCK_50);
    bus.enable = 1'b1;
    bus.length = 10'd3;
    @(negedge CLOCK_50);
    bus.enable = 1'b0;
    wait_idle(busy, amax, wrap);
    chk("ignore_busy",     32'(busy),         32'd7);
    chk("ignore_max",      32'(bus.max_val),  32'd9);
    chk("ignore_checksum", 32'(bus.checksum), exp_sum(32'd45));
    chk("ignore_ready",    32'(bus.ready),    32'd1);

    // asynchronous reset mid-scan
    load5();
    kick(10'd5, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    chk("midrst_pre_addr", 32'(bus.address), 32'd3);
    chk("midrst_pre_min",  32'(bus.min_val), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready",    32'(bus.ready),    32'd1);
    chk("midrst_addr",     32'(bus.address),  32'd0);
    chk("midrst_done",     32'(bus.done),     32'd0);
    chk("midrst_min",      32'(bus.min_val),  32'd0);
    chk("midrst_max",      32'(bus.max_val),  32'd0);
    chk("midrst_checksum", 32'(bus.checksum), 32'd0);
    @(negedge CLOCK_50);
    rst = 1'b0;
    kick(10'd5, 1'b0);
    wait_idle(busy, amax, wrap);
    chk("fresh_busy",     32'(busy),         32'd7);
    chk("fresh_pass",     32'(bus.pass),     32'd0);
    chk("fresh_fail_idx", 32'(bus.fail_idx), 32'd2);
    chk("fresh_min",      32'(bus.min_val),  32'd1);
    chk("fresh_max",      32'(bus.max_val),  32'd7);
    chk("fresh_checksum", 32'(bus.checksum), exp_sum(32'd20));

    // 2,2,2 with enable held: equal neighbours pass, then immediate re-accept
    mem[0] = 8'd2; mem[1] = 8'd2; mem[2] = 8'd2;
    kick(10'd3, 1'b1);
    wait_idle(busy, amax, wrap);
    chk("equal_busy",     32'(busy),         32'd5);
    chk("equal_pass",     32'(bus.pass),     32'd1);
    chk("equal_fail_idx", 32'(bus.fail_idx), 32'd0);
    chk("equal_min",      32'(bus.min_val),  32'd2);
    chk("equal_max",      32'(bus.max_val),  32'd2);
    chk("equal_checksum", 32'(bus.checksum), exp_sum(32'd6));
    @(negedge CLOCK_50);
    chk("b2b_ready_low",  32'(bus.ready), 32'd0);
    chk("b2b_done_clr",   32'(bus.done),  32'd0);
    bus.enable = 1'b0;
    wait_idle(busy, amax, wrap);
    chk("b2b_busy",       32'(busy),         32'd5);
    chk("b2b_done",       32'(bus.done),     32'd1);
    chk("b2b_pass",       32'(bus.pass),     32'd1);
    chk("b2b_max",        32'(bus.max_val),  32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
